// File: rtl/adxl362_spi_arbiter_pkg.sv
// Shared types and ADXL362 register constants for the SPI arbiter.
// The init-only FSM states exist only when ADXL362_INIT_EN is defined.
package adxl362_pkg;

  localparam logic [7:0] ADXL_XDATA     = 8'h08;
  localparam logic [7:0] ADXL_YDATA     = 8'h09;
  localparam logic [7:0] ADXL_ZDATA     = 8'h0A;
  localparam logic [7:0] ADXL_POWER_CTL = 8'h2D;
  localparam logic [7:0] ADXL_MEASURE   = 8'h02;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1
`ifdef ADXL362_INIT_EN
    ,
    INIT_ISSUE = 2'd2,
    INIT_WAIT  = 2'd3
`endif
  } arb_state_t;

endpackage

// File: rtl/adxl362_spi_arbiter_if.sv
// Bundle of the requester-side and controller-side signals of the arbiter.
// master: the arbiter's view. slave: the environment (requesters + controller).
// Handshake: a requester raises req and holds it, with its write/addr/wdata
// stable, until it sees its one-cycle done pulse; grant is informational.
// Toward the controller, ctl_start is a one-cycle pulse and ctl_done a
// one-cycle completion pulse carrying ctl_rdata.
interface adxl362_spi_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import adxl362_pkg::*;

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_write;
  logic [NUM_REQ*8-1:0] req_addr;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 err;
  logic [7:0]           rdata;
  logic                 init_done;
  logic                 ctl_start;
  logic                 ctl_write;
  logic [7:0]           ctl_addr;
  logic [7:0]           ctl_wdata;
  logic                 ctl_busy;
  logic                 ctl_done;
  logic [7:0]           ctl_rdata;
  arb_state_t           state;

  modport master (
    input  req, req_write, req_addr, req_wdata, ctl_busy, ctl_done, ctl_rdata,
    output grant, done, err, rdata, init_done,
    output ctl_start, ctl_write, ctl_addr, ctl_wdata, state
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, ctl_busy, ctl_done, ctl_rdata,
    input  grant, done, err, rdata, init_done,
    input  ctl_start, ctl_write, ctl_addr, ctl_wdata, state
  );

endinterface

// File: rtl/adxl362_spi_arbiter_rr_arbiter.sv
// Round-robin pointer plus combinational winner pick: the first set request
// at or above the pointer, wrapping. The pointer moves past the winner
// only when the caller commits the grant via advance.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand;

  // Scan offsets from highest to lowest so the closest-to-pointer hit wins.
  always_comb begin
    winner  = '0;
    valid   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        winner  = NUM_REQ'(1) << cand;
        win_idx = cand;
        valid   = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1, wrapping, whenever a grant is committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/adxl362_spi_arbiter.sv
// Shares one adxl362_controller port between NUM_REQ requesters with
// round-robin arbitration, one transfer in flight, and a watchdog that
// aborts a transfer whose ctl_done never arrives.
// Optional feature macro: ADXL362_INIT_EN -- issue a POWER_CTL measurement
// mode write after reset before any requester is served.
module adxl362_spi_arbiter
  import adxl362_pkg::*;
#(
  parameter int         NUM_REQ        = 3,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] INIT_ADDR      = ADXL_POWER_CTL,
  parameter logic [7:0] INIT_DATA      = ADXL_MEASURE
) (
  input logic                  clk,
  input logic                  rst,
  adxl362_spi_arbiter_if.master bus
);
  localparam int             WDW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
`ifdef ADXL362_INIT_EN
  localparam arb_state_t     START_STATE = INIT_ISSUE;
`else
  localparam arb_state_t     START_STATE = IDLE;
`endif

  arb_state_t         state;
  logic [WDW-1:0]     wd;
  logic [NUM_REQ-1:0] win;
  logic               win_valid;
  logic               advance;
  logic               sel_write;
  logic [7:0]         sel_addr;
  logic [7:0]         sel_wdata;

  assign bus.state = state;
  assign advance   = (state == IDLE) && !bus.ctl_busy && win_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .advance (advance),
    .winner  (win),
    .valid   (win_valid)
  );

  // Steer the winning requester's command fields toward the controller.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[8*i +: 8];
        sel_wdata = bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Arbiter FSM; every output is registered, start/done are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= START_STATE;
      wd            <= '0;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.err       <= 1'b0;
      bus.rdata     <= '0;
      bus.init_done <= 1'b0;
      bus.ctl_start <= 1'b0;
      bus.ctl_write <= 1'b0;
      bus.ctl_addr  <= '0;
      bus.ctl_wdata <= '0;
    end else begin
      bus.ctl_start <= 1'b0;
      bus.done      <= '0;
      case (state)
`ifdef ADXL362_INIT_EN
        INIT_ISSUE: begin
          bus.ctl_start <= 1'b1;
          bus.ctl_write <= 1'b1;
          bus.ctl_addr  <= INIT_ADDR;
          bus.ctl_wdata <= INIT_DATA;
          wd            <= '0;
          state         <= INIT_WAIT;
        end
        INIT_WAIT: begin
          // A lost ctl_done still releases the requesters after the timeout.
          if (bus.ctl_done || wd == WD_LAST) begin
            bus.init_done <= 1'b1;
            state         <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
`endif
        IDLE: begin
          bus.init_done <= 1'b1;
          if (advance) begin
            bus.grant     <= win;
            bus.ctl_start <= 1'b1;
            bus.ctl_write <= sel_write;
            bus.ctl_addr  <= sel_addr;
            bus.ctl_wdata <= sel_wdata;
            wd            <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // grant still holds the owner one-hot, so it doubles as the done mask.
          if (bus.ctl_done) begin
            bus.rdata <= bus.ctl_rdata;
            bus.done  <= bus.grant;
            bus.err   <= 1'b0;
            bus.grant <= '0;
            state     <= IDLE;
          end else if (wd == WD_LAST) begin
            bus.done  <= bus.grant;
            bus.err   <= 1'b1;
            bus.grant <= '0;
            state     <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adxl362_spi_arbiter.sv
// Directed bench for adxl362_spi_arbiter: main instance with the default
// watchdog, a second instance with a 16-cycle watchdog, and a simple
// controller model per instance whose latency/read data the stimulus sets.
module tb_adxl362_spi_arbiter;
  import adxl362_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int cdone_cyc = 0;

  int         lat_a = 5;
  int         lat_b = 3;
  logic [7:0] rd_a  = 8'h00;
  logic [7:0] rd_b  = 8'h00;
  logic       last_wr;
  logic [7:0] last_addr;
  logic [7:0] last_wdata;
  int         n_start_a = 0;
  int         done_cnt1 = 0;
  int         last_done_cyc = 0;
  bit         have_done = 1'b0;
  bit         fair_on   = 1'b0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] fair_exp[6];

  adxl362_spi_arbiter_if #(.NUM_REQ(N)) a ();
  adxl362_spi_arbiter_if #(.NUM_REQ(N)) b ();

  adxl362_spi_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  adxl362_spi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Cycle counter; also notes the cycle whose edge samples ctl_done on bus a.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a.ctl_done) cdone_cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- controller models ----------------
  initial begin : model_a
    int pend;
    pend = 0;
    a.ctl_busy = 1'b0; a.ctl_done = 1'b0; a.ctl_rdata = 8'h00;
    forever begin
      @(negedge clk);
      a.ctl_done = 1'b0;
      if (rst) begin
        a.ctl_busy = 1'b0; pend = 0;
      end else if (a.ctl_start) begin
        last_wr = a.ctl_write; last_addr = a.ctl_addr; last_wdata = a.ctl_wdata;
        if (lat_a > 0) begin a.ctl_busy = 1'b1; pend = lat_a; end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin a.ctl_done = 1'b1; a.ctl_rdata = rd_a; a.ctl_busy = 1'b0; end
      end
    end
  end

  // lat_b == 0 models a controller that never answers.
  initial begin : model_b
    int pend;
    pend = 0;
    b.ctl_busy = 1'b0; b.ctl_done = 1'b0; b.ctl_rdata = 8'h00;
    forever begin
      @(negedge clk);
      b.ctl_done = 1'b0;
      if (rst) begin
        b.ctl_busy = 1'b0; pend = 0;
      end else if (b.ctl_start) begin
        if (lat_b > 0) begin b.ctl_busy = 1'b1; pend = lat_b; end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin b.ctl_done = 1'b1; b.ctl_rdata = rd_b; b.ctl_busy = 1'b0; end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (a.ctl_start) begin
        n_start_a++;
        if (exp_q.size() > 0) check("grant_at_start", a.grant, exp_q.pop_front());
        else check("unexpected_start", 1, 0);
        if (fair_on && have_done) check("idle_gap", cyc - last_done_cyc, 1);
      end
      if (a.done != '0) begin
        last_done_cyc = cyc;
        have_done = 1'b1;
        if (a.done[1]) done_cnt1++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_start_a(output int c);
    c = 0;
    do begin @(negedge clk); c++; end while (!a.ctl_start && c < 20);
  endtask

  task automatic wait_done_a(input int budget, output int c);
    c = 0;
    do begin @(negedge clk); c++; end while (a.done == '0 && c < budget);
  endtask

  task automatic b_xfer(input logic [7:0] addr, output int sc, output int dc);
    b.req_write[0] = 1'b0;
    b.req_addr[7:0] = addr;
    b.req[0] = 1'b1;
    sc = -1; dc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (b.ctl_start) sc = cyc;
      if (b.done != '0) begin dc = cyc; break; end
    end
    b.req[0] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, a.grant, 0);
    check({tag, "_done"}, a.done, 0);
    check({tag, "_err"}, a.err, 0);
    check({tag, "_rdata"}, a.rdata, 0);
    check({tag, "_ctl_start"}, a.ctl_start, 0);
    check({tag, "_ctl_write"}, a.ctl_write, 0);
    check({tag, "_ctl_addr"}, a.ctl_addr, 0);
    check({tag, "_ctl_wdata"}, a.ctl_wdata, 0);
    check({tag, "_init_done"}, a.init_done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int c, s0, d0, sc, dc, id_cyc, g_cyc;
    bit changed;
    fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100;
    fair_exp[3] = 3'b001; fair_exp[4] = 3'b010; fair_exp[5] = 3'b100;
    a.req = '0; a.req_write = '0; a.req_addr = '0; a.req_wdata = '0;
    b.req = '0; b.req_write = '0; b.req_addr = '0; b.req_wdata = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
`ifdef ADXL362_INIT_EN
    exp_q.push_back('0);
`endif
    rst = 1'b0;
    @(negedge clk);
`ifdef ADXL362_INIT_EN
    check("init_start", a.ctl_start, 1);
    check("init_addr", a.ctl_addr, 8'h2D);
    check("init_wdata", a.ctl_wdata, 8'h02);
    check("init_write", a.ctl_write, 1);
    for (int k = 0; k < 40 && !a.init_done; k++) @(negedge clk);
    check("init_done_up", a.init_done, 1);
    @(negedge clk);
`else
    check("init_done_first_edge", a.init_done, 1);
    check("state_idle", a.state, IDLE);
`endif

    // Round-robin fairness: all three requesters held for six transfers.
    lat_a = 5;
    a.req_addr = {8'h12, 8'h11, 8'h10};
    a.req_write = '0;
    fair_on = 1'b1; have_done = 1'b0;
    for (int t = 0; t < 6; t++) exp_q.push_back(fair_exp[t]);
    a.req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      wait_done_a(100, c);
      check("fair_done", a.done, fair_exp[t]);
      check("fair_grant_clear", a.grant, 0);
      if (t == 5) a.req = '0;
    end
    fair_on = 1'b0;
    repeat (3) @(negedge clk);
    check("fair_all_started", exp_q.size(), 0);

    // Single read by requester 1 of ZDATA, 40-cycle controller latency.
    lat_a = 40; rd_a = 8'h5C;
    s0 = n_start_a; d0 = done_cnt1;
    exp_q.push_back(3'b010);
    a.req_write[1] = 1'b0; a.req_addr[15:8] = ADXL_ZDATA; a.req[1] = 1'b1;
    wait_start_a(c);
    check("rd_start_latency", c, 1);
    check("rd_ctl_addr", a.ctl_addr, 8'h0A);
    check("rd_ctl_write", a.ctl_write, 0);
    wait_done_a(80, c);
    a.req[1] = 1'b0;
    check("rd_done_latency", c, 41);
    check("rd_done", a.done, 3'b010);
    check("rd_rdata", a.rdata, 8'h5C);
    check("rd_err", a.err, 0);
    check("rd_grant_drop", a.grant, 0);
    repeat (4) @(negedge clk);
    check("rd_one_start", n_start_a - s0, 1);
    check("rd_one_done", done_cnt1 - d0, 1);
    check("rd_rdata_held", a.rdata, 8'h5C);

    // Latching: requester 0 writes POWER_CTL, its inputs change mid-transfer.
    lat_a = 20; rd_a = 8'h66;
    exp_q.push_back(3'b001);
    a.req_write[0] = 1'b1; a.req_addr[7:0] = 8'h2D; a.req_wdata[7:0] = 8'h02; a.req[0] = 1'b1;
    wait_start_a(c);
    check("latch_ctl_addr", a.ctl_addr, 8'h2D);
    check("latch_ctl_wdata", a.ctl_wdata, 8'h02);
    check("latch_ctl_write", a.ctl_write, 1);
    @(negedge clk);
    a.req_addr[7:0] = 8'hFF; a.req_wdata[7:0] = 8'h33; a.req_write[0] = 1'b0;
    changed = 1'b0; c = 0;
    do begin
      if (a.ctl_addr != 8'h2D || a.ctl_wdata != 8'h02 || a.ctl_write != 1'b1) changed = 1'b1;
      @(negedge clk); c++;
    end while (a.done == '0 && c < 60);
    a.req[0] = 1'b0;
    check("latch_hold", changed, 0);
    check("latch_addr_at_done", a.ctl_addr, 8'h2D);
    check("latch_done", a.done, 3'b001);
    check("latch_model_addr", last_addr, 8'h2D);

    // Watchdog on the 16-cycle instance.
    lat_b = 3; rd_b = 8'hA7;
    b_xfer(ADXL_XDATA, sc, dc);
    check("to_pre_done", b.done, 3'b001);
    check("to_pre_err", b.err, 0);
    check("to_pre_rdata", b.rdata, 8'hA7);
    lat_b = 0;
    b_xfer(ADXL_YDATA, sc, dc);
    check("to_done", b.done, 3'b001);
    check("to_wait_cycles", dc - sc, 16);
    check("to_err", b.err, 1);
    check("to_rdata_kept", b.rdata, 8'hA7);
    check("to_grant_drop", b.grant, 0);
    lat_b = 4; rd_b = 8'h3C;
    b_xfer(ADXL_ZDATA, sc, dc);
    check("to_next_done", b.done, 3'b001);
    check("to_next_err", b.err, 0);
    check("to_next_rdata", b.rdata, 8'h3C);

    // Reset pulsed while a transfer is waiting on the controller.
    lat_a = 30;
    exp_q.push_back(3'b001);
    a.req_write[0] = 1'b0; a.req_addr[7:0] = 8'h09; a.req[0] = 1'b1;
    wait_start_a(c);
    check("rst_pre_addr", a.ctl_addr, 8'h09);
    repeat (5) @(negedge clk);
    check("rst_pre_state", a.state, WAIT);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    a.req = '0;
`ifdef ADXL362_INIT_EN
    a.req_write[2] = 1'b0; a.req_addr[23:16] = 8'h0A; a.req[2] = 1'b1;
    lat_a = 6; rd_a = 8'h21;
    exp_q.push_back('0);
    exp_q.push_back(3'b100);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef ADXL362_INIT_EN
    wait_start_a(c);
    check("reinit_addr", a.ctl_addr, 8'h2D);
    check("reinit_wdata", a.ctl_wdata, 8'h02);
    check("reinit_write", a.ctl_write, 1);
    check("reinit_grant", a.grant, 0);
    id_cyc = -1; g_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (a.init_done && id_cyc < 0) id_cyc = cyc;
      if (a.grant != '0) begin g_cyc = cyc; break; end
    end
    check("gate_init_done_cyc", id_cyc, cdone_cyc);
    check("gate_grant_cyc", g_cyc, cdone_cyc + 1);
    check("gate_grant", a.grant, 3'b100);
    wait_done_a(40, c);
    a.req[2] = 1'b0;
    check("gate_done", a.done, 3'b100);
    check("gate_rdata", a.rdata, 8'h21);
`else
    @(negedge clk);
    check("rst_release_init_done", a.init_done, 1);
    check("rst_release_state", a.state, IDLE);
    check("rst_release_grant", a.grant, 0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_arbiter.md
# adxl362_spi_arbiter

Shares a single `adxl362_controller` SPI port between `NUM_REQ` requesters, such as the manual read/write button path and the periodic X/Y/Z auto-poll. It sits between the requesters and the controller. Arbitration is round-robin with a req/grant/done handshake, one transfer is outstanding at a time, and a watchdog recovers from a missing `ctl_done`. Optionally, it first runs a power-up write that puts the ADXL362 into measurement mode before any requester is served.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 4096: maximum cycles in WAIT before the transfer is aborted with an error.
- `INIT_ADDR`, 8'h2D: register written by the power-up init (POWER_CTL).
- `INIT_DATA`, 8'h02: value written by the init (measurement mode).

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in NUM_REQ: per-requester transfer request; held high until that requester's `done`.
- `req_write` in NUM_REQ: 1 = write, 0 = read; per requester.
- `req_addr` in NUM_REQ*8: register address; requester i occupies bits [8i+7:8i].
- `req_wdata` in NUM_REQ*8: write data; same packing as `req_addr`.
- `grant` out NUM_REQ: one-hot; the requester currently owning the controller.
- `done` out NUM_REQ: one-cycle pulse to the owning requester at the end of its transfer.
- `err` out 1: valid with `done`; 1 = watchdog timeout.
- `rdata` out 8: read data; valid with `done`, held until the next `done`.
- `init_done` out 1: high once requesters may be served.
- `ctl_start` out 1: one-cycle start pulse to the controller.
- `ctl_write` out 1: write/read select to the controller.
- `ctl_addr` out 8: register address to the controller.
- `ctl_wdata` out 8: write data to the controller.
- `ctl_busy` in 1: controller busy.
- `ctl_done` in 1: controller done pulse.
- `ctl_rdata` in 8: controller read data.

## Operation
- States: INIT_ISSUE, INIT_WAIT (present only when init is compiled in), IDLE, WAIT.
- **Reset values:** `grant`=0, `done`=0, `err`=0, `rdata`=0, `ctl_start`=0, `ctl_write`=0, `ctl_addr`=0, `ctl_wdata`=0, `init_done`=0, round-robin pointer=0.
- **IDLE:** if `ctl_busy`=0 and any `req` bit is 1, pick a winner.
  - The winner is the first set bit, searching upward from the pointer and wrapping.
  - Register `grant`=onehot(winner) and latch that requester's write/address/data into the `ctl_*` outputs.
  - Pulse `ctl_start` and go to WAIT.
  - Set the pointer to winner+1, wrapping at `NUM_REQ`.
- **WAIT:** watchdog counter starts at 0 and increments each cycle.
  - On `ctl_done`: `rdata` ← `ctl_rdata`, pulse `done[winner]` with `err`=0, clear `grant`, go to IDLE.
  - If the counter reaches `TIMEOUT_CYCLES`-1 before `ctl_done`: pulse `done[winner]` with `err`=1, leave `rdata` unchanged, clear `grant`, go to IDLE.
- **Request handling:**
  - `req` or its inputs changing during WAIT does not affect the transfer in flight; the inputs are latched at grant.
  - A requester still holding `req` after its `done` is re-arbitrated like any other, so round-robin prevents starvation.
  - A `ctl_done` seen in IDLE is ignored.
- **Reset mid-transfer:** all outputs return to their reset values immediately; the controller is assumed to be reset by the same `rst`.

## Timing
- `req` sampled high at edge N in IDLE → `grant` and `ctl_*` valid, and `ctl_start`=1, after edge N+1. `ctl_start` stays high for exactly one cycle.
- `ctl_done` high at edge M → `done`/`rdata`/`err` valid after edge M+1. `grant` drops at the same edge.
- The earliest next grant is sampled at edge M+2, which gives one IDLE cycle between transfers.
- Arbitration overhead is 2 cycles per transfer beyond controller latency.

## Configuration
- Macro: `ADXL362_INIT_EN`.
- **Defined:** after reset the FSM starts in INIT_ISSUE.
  - It pulses `ctl_start` with `ctl_write`=1, `INIT_ADDR`, `INIT_DATA`, then goes to INIT_WAIT.
  - `grant` stays 0 and all `req` are ignored during init.
  - On `ctl_done` or watchdog timeout, `init_done` goes to 1 on the next edge and the FSM enters IDLE. No `done` pulse is issued.
- **Undefined:** the FSM starts in IDLE, and `init_done` goes to 1 on the first edge after `rst` deasserts.

## Structure
- Package `adxl362_pkg` holds:
  - the state enum `arb_state_t`;
  - register constants `ADXL_XDATA`=8'h08, `ADXL_YDATA`=8'h09, `ADXL_ZDATA`=8'h0A, `ADXL_POWER_CTL`=8'h2D, `ADXL_MEASURE`=8'h02.
- Sub-module `rr_arbiter`: the pointer register plus combinational winner selection (`req`, `advance` in; `winner` one-hot and `valid` out).

## Test plan
- **Single read:** requester 1 issues a read of 8'h0A; the model returns 8'h5C after 40 cycles → one `ctl_start`, `ctl_addr`=8'h0A, `ctl_write`=0, `done[1]` once, `rdata`=8'h5C, `err`=0.
- **Round-robin fairness:** all three `req` held high for 6 transfers → grant order 0,1,2,0,1,2, with one IDLE cycle between each `done` and the next `ctl_start`.
- **Latching:** requester 0 writes 8'h2D/8'h02, and its address changes to 8'hFF during WAIT → `ctl_addr` remains 8'h2D until `done[0]`.
- **Timeout:** `TIMEOUT_CYCLES`=16 and the model never asserts `ctl_done` → `done` with `err`=1 at cycle 16 of WAIT, `rdata` unchanged, next request served normally.
- **Reset mid-transfer:** `rst` pulsed during WAIT → all outputs at reset values in the same cycle. With `ADXL362_INIT_EN` defined, a fresh init write to 8'h2D/8'h02 follows before any `grant`.
- **Init gating:** with `ADXL362_INIT_EN` defined, `req[2]` held high from reset → no `grant` until one cycle after the init `ctl_done`, then `grant[2]`.
